// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ID/EX ALU control stage:
// ALU control codes, ALUOp/funct encodings, mult/div ops and the decode bundle.
package alu_ctrl_pkg;

   localparam logic [3:0] CTRL_ADD  = 4'b0000;
   localparam logic [3:0] CTRL_SUB  = 4'b0001;
   localparam logic [3:0] CTRL_AND  = 4'b0010;
   localparam logic [3:0] CTRL_OR   = 4'b0011;
   localparam logic [3:0] CTRL_SLL  = 4'b0100;
   localparam logic [3:0] CTRL_SRL  = 4'b0101;
   localparam logic [3:0] CTRL_SRA  = 4'b0110;
   localparam logic [3:0] CTRL_SLTU = 4'b0111;
   localparam logic [3:0] CTRL_SLT  = 4'b1000;
   localparam logic [3:0] CTRL_NOR  = 4'b1001;
   localparam logic [3:0] CTRL_XOR  = 4'b1010;
   localparam logic [3:0] CTRL_LUI  = 4'b1011;
   localparam logic [3:0] CTRL_MFHI = 4'b1100;
   localparam logic [3:0] CTRL_MFLO = 4'b1101;

   localparam logic [3:0] ALUOP_ADD   = 4'b0000;
   localparam logic [3:0] ALUOP_SUB   = 4'b0001;
   localparam logic [3:0] ALUOP_RTYPE = 4'b0010;
   localparam logic [3:0] ALUOP_AND   = 4'b0011;
   localparam logic [3:0] ALUOP_OR    = 4'b0100;
   localparam logic [3:0] ALUOP_SLT   = 4'b0101;
   localparam logic [3:0] ALUOP_XOR   = 4'b0110;
   localparam logic [3:0] ALUOP_LUI   = 4'b0111;
   localparam logic [3:0] ALUOP_SLTU  = 4'b1000;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLTU  = 6'b101011;
   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_SRA   = 6'b000011;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } mdState_e;

   typedef struct packed {
      logic [3:0] code;
      logic       isMd;
      logic [1:0] mdOp;
      logic       isMfhilo;
      logic       illegal;
   } decode_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Purely combinational ALUOp/funct decoder; anything unlisted comes out as
// code 0000 with illegal set, so no X ever reaches the output register.
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
#(
   parameter int ALUOP_W = 4
) (
   input  logic [ALUOP_W-1:0] aluop_i,
   input  logic [5:0]         funct_i,
   output decode_t            dec_o
);

   always_comb begin
      dec_o = '0;
      case (aluop_i)
         ALUOP_W'(ALUOP_ADD):  dec_o.code = CTRL_ADD;
         ALUOP_W'(ALUOP_SUB):  dec_o.code = CTRL_SUB;
         ALUOP_W'(ALUOP_AND):  dec_o.code = CTRL_AND;
         ALUOP_W'(ALUOP_OR):   dec_o.code = CTRL_OR;
         ALUOP_W'(ALUOP_SLT):  dec_o.code = CTRL_SLT;
         ALUOP_W'(ALUOP_XOR):  dec_o.code = CTRL_XOR;
         ALUOP_W'(ALUOP_LUI):  dec_o.code = CTRL_LUI;
         ALUOP_W'(ALUOP_SLTU): dec_o.code = CTRL_SLTU;
         ALUOP_W'(ALUOP_RTYPE): begin
            case (funct_i)
               FN_ADD, FN_ADDU: dec_o.code = CTRL_ADD;
               FN_SUB, FN_SUBU: dec_o.code = CTRL_SUB;
               FN_AND:          dec_o.code = CTRL_AND;
               FN_OR:           dec_o.code = CTRL_OR;
               FN_XOR:          dec_o.code = CTRL_XOR;
               FN_NOR:          dec_o.code = CTRL_NOR;
               FN_SLT:          dec_o.code = CTRL_SLT;
               FN_SLTU:         dec_o.code = CTRL_SLTU;
               FN_SLL:          dec_o.code = CTRL_SLL;
               FN_SRL:          dec_o.code = CTRL_SRL;
               FN_SRA:          dec_o.code = CTRL_SRA;
               FN_MFHI: begin
                  dec_o.code     = CTRL_MFHI;
                  dec_o.isMfhilo = 1'b1;
               end
               FN_MFLO: begin
                  dec_o.code     = CTRL_MFLO;
                  dec_o.isMfhilo = 1'b1;
               end
               // The low two funct bits of mult/multu/div/divu are the md_op encoding.
               FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                  dec_o.code = CTRL_ADD;
                  dec_o.isMd = 1'b1;
                  dec_o.mdOp = funct_i[1:0];
               end
               default: dec_o.illegal = 1'b1;
            endcase
         end
         default: dec_o.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// ID/EX ALU control stage: valid/ready output register, flush, and mult/div sequencer.
// Build option ALU_CTRL_TRAP_EN: illegal ops raise a one-cycle trap instead of flowing through.
module alu_ctrl_pipe
   import alu_ctrl_pkg::*;
#(
   parameter int ALUOP_W   = 4,
   parameter int CTRL_W    = 4,
   parameter int MD_CYCLES = 32,
   parameter int CNT_W     = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [ALUOP_W-1:0] aluop_i,
   input  logic [5:0]         funct_i,
   input  logic               flush_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [CTRL_W-1:0]  alu_ctrl_o,
   output logic               md_start_o,
   output logic [1:0]         md_op_o,
   output logic               md_busy_o,
   output logic               illegal_op_o
);

   decode_t            dec;
   mdState_e           state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               outValid_q, outValid_d;
   logic               illegal_q, illegal_d;
   logic               mdStart_q, mdStart_d;
   logic [CTRL_W-1:0]  aluCtrl_q, aluCtrl_d;
   logic [1:0]         mdOp_q, mdOp_d;
   logic               mdBusy, hazard, inReady, accept;

   alu_ctrl_decode #(.ALUOP_W(ALUOP_W)) u_decode (
      .aluop_i (aluop_i),
      .funct_i (funct_i),
      .dec_o   (dec)
   );

   // HI/LO consumers and new mult/div ops must wait until the unit is free.
   assign mdBusy  = (state_q == MD_BUSY);
   assign hazard  = mdBusy & (dec.isMd | dec.isMfhilo);
   assign inReady = (~outValid_q | out_ready_i) & ~hazard & ~flush_i;
   assign accept  = in_valid_i & inReady;

   always_comb begin
      outValid_d = outValid_q;
      illegal_d  = illegal_q;
      aluCtrl_d  = aluCtrl_q;
      if (flush_i) begin
         outValid_d = 1'b0;
         illegal_d  = 1'b0;
      end else if (accept) begin
         aluCtrl_d = CTRL_W'(dec.code);
         illegal_d = dec.illegal;
`ifdef ALU_CTRL_TRAP_EN
         outValid_d = ~dec.illegal;
`else
         outValid_d = 1'b1;
`endif
      end else if (~outValid_q | out_ready_i) begin
         outValid_d = 1'b0;
         illegal_d  = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mdStart_d = 1'b0;
      mdOp_d    = mdOp_q;
      case (state_q)
         MD_IDLE: begin
            if (accept & dec.isMd) begin
               state_d   = MD_BUSY;
               cnt_d     = CNT_W'(MD_CYCLES - 1);
               mdStart_d = 1'b1;
               mdOp_d    = dec.mdOp;
            end
         end
         MD_BUSY: begin
            if (cnt_q == '0) state_d = MD_IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= MD_IDLE;
         cnt_q      <= '0;
         outValid_q <= 1'b0;
         illegal_q  <= 1'b0;
         mdStart_q  <= 1'b0;
         aluCtrl_q  <= '0;
         mdOp_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         outValid_q <= outValid_d;
         illegal_q  <= illegal_d;
         mdStart_q  <= mdStart_d;
         aluCtrl_q  <= aluCtrl_d;
         mdOp_q     <= mdOp_d;
      end
   end

   assign in_ready_o   = inReady;
   assign out_valid_o  = outValid_q;
   assign alu_ctrl_o   = aluCtrl_q;
   assign md_start_o   = mdStart_q;
   assign md_op_o      = mdOp_q;
   assign md_busy_o    = mdBusy;
   assign illegal_op_o = illegal_q;

endmodule
